conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_sched.sv | 169 ++++++++++++++++
 tb/tb_conv_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// conv_sched: job sequencer for an im2col + systolic-array convolution engine.
//
// A job walks IDLE -> IM2COL -> FEED -> DRAIN -> WB -> FIN -> IDLE. IM2COL and
// DRAIN wait on completion strobes from the engines; FEED presents N operand
// rows one per cycle; WB strobes M*K result words to OUTPUT_BASE onward.
// abort (synchronous) returns any busy state to IDLE with no done pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          job request pulse / synchronous cancel
//   busy, done            non-IDLE flag / one-cycle completion pulse
//   im2col_rst_n          im2col enable, high only in IM2COL
//   im2col_done           im2col finished (observed only in IM2COL)
//   sa_rst_n              systolic array enable, high in FEED and DRAIN
//   sa_done               systolic array finished (observed only in DRAIN)
//   feed_valid, feed_idx  operand row strobe and row index 0..N-1
//   wb_en, wb_addr,       result write strobe, address OUTPUT_BASE+i,
//   wb_sel                and flattened result index 0..M*K-1
//   mem_sel               memory write port owner: 0 = im2col, 1 = scheduler
//
// Optional feature: define CONV_SCHED_PERF_EN to add output cycle_cnt[31:0],
// a saturating count of busy cycles from start acceptance up to FIN.

module conv_sched #(
    parameter int unsigned M          = 25,
    parameter int unsigned N          = 36,
    parameter int unsigned K          = 7,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(32'h00003000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  im2col_rst_n,
    input  logic                  im2col_done,
    output logic                  sa_rst_n,
    input  logic                  sa_done,
    output logic                  feed_valid,
    output logic [31:0]           feed_idx,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [31:0]           wb_sel,
    output logic                  mem_sel
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    localparam logic [31:0] FEED_LAST = 32'(N - 1);
    localparam logic [31:0] WB_LAST   = 32'(M * K - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIm2col,
        StFeed,
        StDrain,
        StWb,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start && !abort) state_d = StIm2col;
            StIm2col: if (im2col_done) state_d = StFeed;
            StFeed:   if (cnt_q == FEED_LAST) state_d = StDrain;
            StDrain:  if (sa_done) state_d = StWb;
            StWb:     if (cnt_q == WB_LAST) state_d = StFin;
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // abort outranks every other event in a busy state
        if (abort && (state_q != StIdle)) state_d = StIdle;

        // cnt restarts from zero on every state entry
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == StFeed) || (state_q == StWb)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs decode the registered state only, so reset clears them at once.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        im2col_rst_n = 1'b0;
        sa_rst_n     = 1'b0;
        feed_valid   = 1'b0;
        feed_idx     = '0;
        wb_en        = 1'b0;
        wb_addr      = '0;
        wb_sel       = '0;
        mem_sel      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StIm2col: begin
                busy         = 1'b1;
                im2col_rst_n = 1'b1;
            end
            StFeed: begin
                busy       = 1'b1;
                sa_rst_n   = 1'b1;
                feed_valid = 1'b1;
                feed_idx   = cnt_q;
            end
            StDrain: begin
                busy     = 1'b1;
                sa_rst_n = 1'b1;
            end
            StWb: begin
                busy    = 1'b1;
                mem_sel = 1'b1;
                wb_en   = 1'b1;
                wb_sel  = cnt_q;
                wb_addr = OUTPUT_BASE + ADDR_WIDTH'(cnt_q);  // wraps at 2^ADDR_WIDTH
            end
            StFin: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    // FIN does not count, so the value seen during FIN is held until next start.
    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == StIdle) && start && !abort) begin
            cyc_d = '0;
        end else if ((state_q != StIdle) && (state_q != StFin) && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

    localparam int unsigned M  = 25;
    localparam int unsigned N  = 36;
    localparam int unsigned K  = 7;
    localparam int unsigned NW = M * K;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        im2col_done = 1'b0;
    logic        sa_done = 1'b0;
    logic        busy, done, im2col_rst_n, sa_rst_n, feed_valid, wb_en, mem_sel;
    logic [31:0] feed_idx, wb_addr, wb_sel;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    conv_sched #(
        .M          (M),
        .N          (N),
        .K          (K),
        .ADDR_WIDTH (32),
        .OUTPUT_BASE(32'h00003000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .im2col_rst_n(im2col_rst_n),
        .im2col_done (im2col_done),
        .sa_rst_n    (sa_rst_n),
        .sa_done     (sa_done),
        .feed_valid  (feed_valid),
        .feed_idx    (feed_idx),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_sel      (wb_sel),
        .mem_sel     (mem_sel)
`ifdef CONV_SCHED_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-job monitor state
    int exp_feed, exp_wb, done_cnt, busy_cycles;

    task automatic job_clear();
        exp_feed    = 0;
        exp_wb      = 0;
        done_cnt    = 0;
        busy_cycles = 0;
    endtask

    // Advance one clock, sample 1 ns after the edge and check streaming outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (feed_valid) begin
            check("feed_idx", 64'(feed_idx), 64'(exp_feed));
            check("feed_sa_en", 64'(sa_rst_n), 64'd1);
            exp_feed++;
        end
        if (wb_en) begin
            check("wb_sel", 64'(wb_sel), 64'(exp_wb));
            check("wb_addr", 64'(wb_addr), 64'(32'(32'h3000 + exp_wb)));
            check("wb_mem_sel", 64'(mem_sel), 64'd1);
            exp_wb++;
        end
        if (done) done_cnt++;
        if (busy && !done) busy_cycles++;
    endtask

    function automatic logic [6:0] ctl_bits();
        return {busy, done, im2col_rst_n, sa_rst_n, feed_valid, wb_en, mem_sel};
    endfunction

    // One job; abort_at < 0 runs to completion, else aborts in WB at that cnt.
    task automatic run_job(input int im_cycles, input int dr_cycles, input int abort_at);
        job_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_im2col", 64'(ctl_bits()), 64'(7'b1010000));
        for (int i = 0; i < im_cycles - 1; i++) begin
            start = (i == 2);  // ignored while busy
            tick();
            start = 1'b0;
        end
        check("im2col_hold", 64'(ctl_bits()), 64'(7'b1010000));
        im2col_done = 1'b1;
        tick();
        im2col_done = 1'b0;
        for (int g = 0; g < 100 && feed_valid; g++) begin
            sa_done = (g == 5);  // ignored outside DRAIN
            start   = (g == 7);
            tick();
            sa_done = 1'b0;
            start   = 1'b0;
        end
        check("feed_count", 64'(exp_feed), 64'(N));
        check("drain_entry", 64'(ctl_bits()), 64'(7'b1001000));
        repeat (dr_cycles - 1) tick();
        check("drain_hold", 64'(ctl_bits()), 64'(7'b1001000));
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        check("wb_entry", 64'(ctl_bits()), 64'(7'b1000011));
        for (int g = 0; g < 400 && wb_en; g++) begin
            if (abort_at >= 0 && exp_wb == abort_at + 1) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        if (abort_at < 0) begin
            check("wb_count", 64'(exp_wb), 64'(NW));
            check("fin_state", 64'(ctl_bits()), 64'(7'b1100000));
`ifdef CONV_SCHED_PERF_EN
            check("perf_fin_measured", 64'(cycle_cnt), 64'(busy_cycles));
            check("perf_fin_value", 64'(cycle_cnt), 64'(im_cycles + N + dr_cycles + NW));
`endif
            tick();
            check("post_fin_idle", 64'(ctl_bits()), 64'(7'b0000000));
            repeat (3) tick();
            check("done_once", 64'(done_cnt), 64'd1);
`ifdef CONV_SCHED_PERF_EN
            check("perf_frozen", 64'(cycle_cnt), 64'(im_cycles + N + dr_cycles + NW));
`endif
        end else begin
            check("abort_wb_count", 64'(exp_wb), 64'(abort_at + 1));
            check("abort_idle", 64'(ctl_bits()), 64'(7'b0000000));
            repeat (5) tick();
            check("abort_no_done", 64'(done_cnt), 64'd0);
            check("abort_no_more_wb", 64'(exp_wb), 64'(abort_at + 1));
        end
    endtask

    typedef struct {
        logic        st, ab, id, sd;
        logic [6:0]  exp_ctl;  // {busy,done,im2col_rst_n,sa_rst_n,feed_valid,wb_en,mem_sel}
        logic [31:0] exp_idx;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic ab, input logic id, input logic sd,
                                input logic [6:0] e, input int idx, input string n);
        vec_t v;
        v.st = st; v.ab = ab; v.id = id; v.sd = sd;
        v.exp_ctl = e;
        v.exp_idx = 32'(idx);
        v.name = n;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 7'b0000000, 0, "t_idle");
        vecs[1]  = mk(1, 1, 0, 0, 7'b0000000, 0, "t_start_abort_idle");
        vecs[2]  = mk(1, 0, 0, 0, 7'b1010000, 0, "t_start");
        vecs[3]  = mk(1, 0, 0, 0, 7'b1010000, 0, "t_start_ignored");
        vecs[4]  = mk(0, 0, 0, 1, 7'b1010000, 0, "t_sa_done_in_im2col");
        vecs[5]  = mk(0, 0, 1, 0, 7'b1001100, 0, "t_feed0");
        vecs[6]  = mk(0, 0, 0, 0, 7'b1001100, 1, "t_feed1");
        vecs[7]  = mk(0, 0, 1, 0, 7'b1001100, 2, "t_im2col_done_in_feed");
        vecs[8]  = mk(0, 1, 0, 0, 7'b0000000, 0, "t_abort_feed");
        vecs[9]  = mk(1, 0, 1, 0, 7'b1010000, 0, "t_start_with_im2col_done");
        vecs[10] = mk(0, 0, 1, 0, 7'b1001100, 0, "t_im2col_entry_done");
        vecs[11] = mk(0, 1, 0, 0, 7'b0000000, 0, "t_abort_feed2");
        vecs[12] = mk(0, 1, 0, 0, 7'b0000000, 0, "t_abort_in_idle");

        // Reset state, observed before any clock edge
        #3;
        check("reset_ctl", 64'(ctl_bits()), 64'(7'b0000000));
        check("reset_feed_idx", 64'(feed_idx), 64'd0);
        check("reset_wb_addr", 64'(wb_addr), 64'd0);
        check("reset_wb_sel", 64'(wb_sel), 64'd0);
`ifdef CONV_SCHED_PERF_EN
        check("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start       = vecs[i].st;
            abort       = vecs[i].ab;
            im2col_done = vecs[i].id;
            sa_done     = vecs[i].sd;
            @(posedge clk);
            #1;
            check(vecs[i].name, 64'(ctl_bits()), 64'(vecs[i].exp_ctl));
            check({vecs[i].name, "_idx"}, 64'(feed_idx), 64'(vecs[i].exp_idx));
        end
        start = 1'b0; abort = 1'b0; im2col_done = 1'b0; sa_done = 1'b0;
        repeat (2) tick();

        run_job(10, 20, -1);
        run_job(10, 20, 50);
        run_job(1, 1, -1);

        // Asynchronous reset in the middle of FEED
        job_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        im2col_done = 1'b1;
        tick();
        im2col_done = 1'b0;
        repeat (3) tick();
        check("pre_reset_feed", 64'(ctl_bits()), 64'(7'b1001100));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", 64'(ctl_bits()), 64'(7'b0000000));
        check("async_reset_feed_idx", 64'(feed_idx), 64'd0);
        check("async_reset_wb", 64'({wb_addr, wb_sel}), 64'd0);
`ifdef CONV_SCHED_PERF_EN
        check("async_reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", 64'(ctl_bits()), 64'(7'b0000000));

        run_job(10, 20, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
